// File: rtl/instr_decode_pipe.sv
// RV32I decode stage: combinational decode + operand read, registered output with a 2-entry skid.
// Optional writeback bypass into the operand read is enabled by defining DECODE_BYPASS_EN.
module instr_decode_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      raddr1,
  output logic [4:0]      raddr2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jump,
  output logic            is_reg,
  output logic            is_alu,
  output logic            illegal,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] branch_dest,
  output logic [4:0]      dest,
  output logic [2:0]      func3,
  output logic            func7
);

  typedef struct packed {
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            is_reg;
    logic            is_alu;
    logic            illegal;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] branch_dest;
    logic [4:0]      dest;
    logic [2:0]      func3;
    logic            func7;
  } dec_t;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_SKID  = 2'd2;
  localparam logic [5:0] NR      = 6'(NUM_REGS);

  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd;
  logic op_load, op_store, op_branch, op_jal, op_jalr, op_op, op_opimm, op_lui, op_auipc;
  logic use_rs1, use_rs2, use_rd, bad_idx, ill;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x, rv1, rv2;
  dec_t dec, out_q, skid_q;
  logic [1:0] state, state_n;
  logic accept;

  assign opc    = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign raddr1 = rs1;
  assign raddr2 = rs2;

  assign op_load   = opc == 7'b0000011;
  assign op_store  = opc == 7'b0100011;
  assign op_branch = opc == 7'b1100011;
  assign op_jal    = opc == 7'b1101111;
  assign op_jalr   = opc == 7'b1100111;
  assign op_op     = opc == 7'b0110011;
  assign op_opimm  = opc == 7'b0010011;
  assign op_lui    = opc == 7'b0110111;
  assign op_auipc  = opc == 7'b0010111;

  assign use_rs1 = op_load | op_store | op_branch | op_jalr | op_op | op_opimm;
  assign use_rs2 = op_store | op_branch | op_op;
  assign use_rd  = op_load | op_jal | op_jalr | op_op | op_opimm | op_lui | op_auipc;
  assign bad_idx = (use_rs1 & ({1'b0, rs1} >= NR)) |
                   (use_rs2 & ({1'b0, rs2} >= NR)) |
                   (use_rd  & ({1'b0, rd}  >= NR));
  assign ill     = ~(use_rd | op_store | op_branch) | (instr[1:0] != 2'b11) | bad_idx;

  always_comb begin
    imm32 = '0;
    if (op_load | op_jalr | op_opimm) imm32 = {{20{instr[31]}}, instr[31:20]};
    else if (op_store)                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    else if (op_branch)               imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (op_lui | op_auipc)       imm32 = {instr[31:12], 12'b0};
    else if (op_jal)                  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end
  assign imm_x = XLEN'($signed(imm32));

`ifdef DECODE_BYPASS_EN
  // Forward a same-cycle writeback so the operand is not stale; x0 is hardwired zero.
  assign rv1 = (rs1 == 5'd0) ? '0 : (wb_en && wb_addr == rs1) ? wb_data : rdata1;
  assign rv2 = (rs2 == 5'd0) ? '0 : (wb_en && wb_addr == rs2) ? wb_data : rdata2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr, wb_data};
  assign rv1 = rdata1;
  assign rv2 = rdata2;
`endif

  always_comb begin
    dec             = '0;
    dec.illegal     = ill;
    dec.is_load     = op_load & ~ill;
    dec.is_store    = op_store & ~ill;
    dec.is_branch   = op_branch & ~ill;
    dec.is_jump     = (op_jal | op_jalr) & ~ill;
    dec.is_reg      = use_rs1 & ~ill;
    dec.is_alu      = (op_op | op_opimm | op_lui | op_auipc) & ~ill;
    dec.imm         = imm_x;
    dec.operand_a   = (op_jal | op_auipc) ? pc : op_lui ? '0 : rv1;
    dec.operand_b   = use_rs2 ? rv2 : imm_x;
    dec.branch_dest = (op_branch | op_jal) ? pc + imm_x : '0;
    dec.dest        = (use_rd & ~ill) ? rd : 5'd0;
    dec.func3       = instr[14:12];
    dec.func7       = instr[30];
  end

  assign in_ready  = state != S_SKID;
  assign out_valid = state != S_EMPTY;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_n = state;
    case (state)
      S_EMPTY: if (accept) state_n = S_FULL;
      S_FULL: begin
        if (accept & ~out_ready)      state_n = S_SKID;
        else if (~accept & out_ready) state_n = S_EMPTY;
      end
      S_SKID:  if (out_ready) state_n = S_FULL;
      default: state_n = S_EMPTY;
    endcase
    if (flush) state_n = S_EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state <= state_n;
      // Flushed beats leave stale data behind, but out_valid is already low.
      if (!flush) begin
        case (state)
          S_EMPTY: if (accept) out_q <= dec;
          S_FULL: begin
            if (accept & out_ready) out_q  <= dec;
            else if (accept)        skid_q <= dec;
          end
          S_SKID:  if (out_ready) out_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign is_load     = out_q.is_load;
  assign is_store    = out_q.is_store;
  assign is_branch   = out_q.is_branch;
  assign is_jump     = out_q.is_jump;
  assign is_reg      = out_q.is_reg;
  assign is_alu      = out_q.is_alu;
  assign illegal     = out_q.illegal;
  assign operand_a   = out_q.operand_a;
  assign operand_b   = out_q.operand_b;
  assign imm         = out_q.imm;
  assign branch_dest = out_q.branch_dest;
  assign dest        = out_q.dest;
  assign func3       = out_q.func3;
  assign func7       = out_q.func7;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Bench for instr_decode_pipe: vector table through a scoreboard, plus skid, flush and reset sequences.
// A second instance with NUM_REGS=16 runs in lockstep to check RV32E index legality.
module tb_instr_decode_pipe;

  typedef struct {
    logic [31:0] instr, pc, r1, r2;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic [6:0]  flags;  // {load,store,branch,jump,reg,alu,illegal}
    logic [31:0] opa, opb, imm, bd;
    logic [4:0]  dest;
    logic [2:0]  f3;
    logic        f7;
    logic        ill16;
  } vec_t;

`ifdef DECODE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  localparam logic [31:0] R1 = 32'h11111111;
  localparam logic [31:0] R2 = 32'h22222222;
  localparam int NV = 14;

  logic clk = 1'b0, reset;
  logic in_valid, in_ready, wb_en, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rdata1, rdata2, wb_data;
  logic [4:0] raddr1, raddr2, wb_addr, dest;
  logic is_load, is_store, is_branch, is_jump, is_reg, is_alu, illegal, func7;
  logic [31:0] operand_a, operand_b, imm, branch_dest;
  logic [2:0] func3;

  logic o16_in_ready, o16_out_valid, o16_ld, o16_st, o16_br, o16_jp, o16_rg, o16_alu, o16_illegal, o16_f7;
  logic [4:0] o16_ra1, o16_ra2, o16_dest;
  logic [31:0] o16_opa, o16_opb, o16_imm, o16_bd;
  logic [2:0] o16_f3;
  wire unused_o16 = ^{o16_in_ready, o16_out_valid, o16_ld, o16_st, o16_br, o16_jp, o16_rg, o16_alu,
                      o16_f7, o16_ra1, o16_ra2, o16_opa, o16_opb, o16_imm, o16_bd, o16_f3};

  int checks = 0, errors = 0;
  logic rand_ready = 1'b0;
  vec_t tv[NV];
  vec_t sb[$];

  always #5 clk = ~clk;

  instr_decode_pipe #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
    .is_reg(is_reg), .is_alu(is_alu), .illegal(illegal),
    .operand_a(operand_a), .operand_b(operand_b), .imm(imm), .branch_dest(branch_dest),
    .dest(dest), .func3(func3), .func7(func7));

  instr_decode_pipe #(.XLEN(32), .NUM_REGS(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o16_in_ready), .instr(instr), .pc(pc),
    .raddr1(o16_ra1), .raddr2(o16_ra2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(o16_out_valid), .out_ready(out_ready),
    .is_load(o16_ld), .is_store(o16_st), .is_branch(o16_br), .is_jump(o16_jp),
    .is_reg(o16_rg), .is_alu(o16_alu), .illegal(o16_illegal),
    .operand_a(o16_opa), .operand_b(o16_opb), .imm(o16_imm), .branch_dest(o16_bd),
    .dest(o16_dest), .func3(o16_f3), .func7(o16_f7));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input vec_t e);
    chk("flags", {25'b0, is_load, is_store, is_branch, is_jump, is_reg, is_alu, illegal}, {25'b0, e.flags});
    chk("operand_a", operand_a, e.opa);
    chk("operand_b", operand_b, e.opb);
    chk("imm", imm, e.imm);
    chk("branch_dest", branch_dest, e.bd);
    chk("dest", {27'b0, dest}, {27'b0, e.dest});
    chk("func3", {29'b0, func3}, {29'b0, e.f3});
    chk("func7", {31'b0, func7}, {31'b0, e.f7});
    chk("illegal16", {31'b0, o16_illegal}, {31'b0, e.ill16});
    chk("dest16", {27'b0, o16_dest}, e.ill16 ? 32'd0 : {27'b0, e.dest});
  endtask

  // Scoreboard: the head entry must be on the output whenever out_valid is high.
  initial forever begin
    @(negedge clk);
    if (!reset && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
      else begin
        cmp_out(sb[0]);
        if (flush) sb.delete();
        else if (out_ready) void'(sb.pop_front());
      end
    end else if (flush) sb.delete();
  end

  task automatic apply(input int i);
    in_valid = 1'b1;
    instr = tv[i].instr; pc = tv[i].pc; rdata1 = tv[i].r1; rdata2 = tv[i].r2;
    wb_en = tv[i].wbe; wb_addr = tv[i].wba; wb_data = tv[i].wbd;
    #0 chk("raddr1", {27'b0, raddr1}, {27'b0, tv[i].instr[19:15]});
    chk("raddr2", {27'b0, raddr2}, {27'b0, tv[i].instr[24:20]});
  endtask

  task automatic wait_acc(input int i);
    int n = 0;
    forever begin
      @(negedge clk);
      if (in_ready && !flush) begin sb.push_back(tv[i]); break; end
      if (++n > 100) begin chk("accept_timeout", 32'd0, 32'd1); break; end
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input int i);
    @(posedge clk); #1;
    apply(i);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    wait_acc(i);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; instr = '0; rdata1 = 32'hDEADBEEF; rdata2 = 32'hBEEFDEAD;
    wb_en = 1'b0; out_ready = 1'b1; rand_ready = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{32'h7D0001EF, 32'h100, R1, R2, 1'b0, 5'd0, 32'd0, 7'b0001000, 32'h100, 32'h7D0, 32'h7D0, 32'h8D0, 5'd3, 3'd0, 1'b1, 1'b0};
    tv[1]  = '{32'h00508A13, 32'h200, R1, R2, 1'b0, 5'd0, 32'd0, 7'b0000110, R1, 32'h5, 32'h5, 32'h0, 5'd20, 3'd0, 1'b0, 1'b1};
    tv[2]  = '{32'h407302B3, 32'h204, R1, R2, 1'b0, 5'd0, 32'd0, 7'b0000110, R1, R2, 32'h0, 32'h0, 5'd5, 3'd0, 1'b1, 1'b0};
    tv[3]  = '{32'hFFC12403, 32'h208, R1, R2, 1'b0, 5'd0, 32'd0, 7'b1000100, R1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0, 5'd8, 3'd2, 1'b1, 1'b0};
    tv[4]  = '{32'h00952423, 32'h20C, R1, R2, 1'b0, 5'd0, 32'd0, 7'b0100100, R1, R2, 32'h8, 32'h0, 5'd0, 3'd2, 1'b0, 1'b0};
    tv[5]  = '{32'hFE208CE3, 32'h1000, R1, R2, 1'b0, 5'd0, 32'd0, 7'b0010100, R1, R2, 32'hFFFFFFF8, 32'hFF8, 5'd0, 3'd0, 1'b1, 1'b0};
    tv[6]  = '{32'hABCDE3B7, 32'h210, R1, R2, 1'b0, 5'd0, 32'd0, 7'b0000010, 32'h0, 32'hABCDE000, 32'hABCDE000, 32'h0, 5'd7, 3'd6, 1'b0, 1'b0};
    tv[7]  = '{32'h00001097, 32'h300, R1, R2, 1'b0, 5'd0, 32'd0, 7'b0000010, 32'h300, 32'h1000, 32'h1000, 32'h0, 5'd1, 3'd1, 1'b0, 1'b0};
    tv[8]  = '{32'h0000007F, 32'h304, 32'h0, R2, 1'b0, 5'd0, 32'd0, 7'b0000001, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b1};
    tv[9]  = '{32'h00508A10, 32'h308, R1, R2, 1'b0, 5'd0, 32'd0, 7'b0000001, R1, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b1};
    tv[10] = '{32'h0200006F, 32'hFFFFFFF0, R1, R2, 1'b0, 5'd0, 32'd0, 7'b0001000, 32'hFFFFFFF0, 32'h20, 32'h20, 32'h10, 5'd0, 3'd0, 1'b0, 1'b0};
    tv[11] = '{32'h7D0F8167, 32'h400, 32'h0, R2, 1'b1, 5'd31, 32'd12345, 7'b0001100, BYP ? 32'd12345 : 32'd0, 32'd2000, 32'd2000, 32'h0, 5'd2, 3'd0, 1'b1, 1'b1};
    tv[12] = '{32'h00100093, 32'h404, 32'h0, R2, 1'b1, 5'd0, 32'hDEAD, 7'b0000110, 32'h0, 32'h1, 32'h1, 32'h0, 5'd1, 3'd0, 1'b0, 1'b0};
    tv[13] = '{32'h007302B3, 32'h408, R1, R2, 1'b1, 5'd7, 32'h77, 7'b0000110, R1, BYP ? 32'h77 : R2, 32'h0, 32'h0, 5'd5, 3'd0, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; rdata1 = '0; rdata2 = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_flags", {25'b0, is_load, is_store, is_branch, is_jump, is_reg, is_alu, illegal}, 32'd0);
    chk("rst_operands", operand_a | operand_b | imm | branch_dest, 32'd0);
    chk("rst_fields", {23'b0, dest, func3, func7}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Table pass at full throughput, then with random back-pressure.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) send(i);
    idle();
    rand_ready = 1'b1;
    for (int i = 0; i < NV; i++) send(i);
    idle();

    // Skid: three beats against a stalled consumer, then release.
    @(posedge clk); #1 out_ready = 1'b0;
    apply(0); wait_acc(0);
    @(posedge clk); #1 apply(1); wait_acc(1);
    @(posedge clk); #1 apply(2);
    @(negedge clk) chk("skid_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk) chk("skid_hold_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_acc(2);
    idle();

    // Flush while in SKID with a third beat on offer.
    @(posedge clk); #1 out_ready = 1'b0;
    apply(3); wait_acc(3);
    @(posedge clk); #1 apply(4); wait_acc(4);
    @(posedge clk); #1 apply(5); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) @(negedge clk) chk("flush_no_output", {31'b0, out_valid}, 32'd0);
    send(6);
    idle();

    // Asynchronous reset while a beat is held.
    @(posedge clk); #1 out_ready = 1'b0;
    send(7);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_operands", operand_a | imm, 32'd0);
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk) chk("arst_idle", {31'b0, out_valid}, 32'd0);
    send(0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
